// File: rtl/fb_fill_ctrl_if.sv
// CPU data-bus connection for the framebuffer fill controller.
interface fb_fill_ctrl_if;
  logic        sel;
  logic        we;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (output sel, we, addr, din, input dout);
  modport slave  (input sel, we, addr, din, output dout);
endinterface

// File: rtl/fb_fill_ctrl.sv
// Framebuffer write controller: CPU pixel stores pass through, and a
// register-programmed engine fills rectangles one pixel per cycle when the port is free.
module fb_fill_ctrl #(
  parameter int unsigned FB_W = 640,
  parameter int unsigned FB_H = 480
) (
  input  logic                clock,
  input  logic                reset,
  fb_fill_ctrl_if.slave       bus,
  output logic                fb_sel,
  output logic                fb_we,
  output logic [31:0]         fb_addr,
  output logic [31:0]         fb_din,
  output logic                busy
);

  typedef enum logic {IDLE, FILL} state_t;

  localparam logic [11:0] FB_W_L = 12'(FB_W);
  localparam logic [11:0] FB_H_L = 12'(FB_H);

  state_t state, state_nxt;

  logic [9:0]  x0_q, w_q;
  logic [8:0]  y0_q, h_q;
  logic [5:0]  color_q;
  logic        done_q;

  logic [10:0] wx0, x_end, y_end, cx, cy;
  logic [5:0]  wcolor;

  logic        cpu_store, reg_wr, reg_rd, pix_rd;
  logic [2:0]  idx;
  logic        start_req, clr_req, empty, step, last_px, on_screen;

  assign idx       = bus.addr[4:2];
  assign cpu_store = bus.sel &  bus.we & ~bus.addr[20];
  assign reg_wr    = bus.sel &  bus.we &  bus.addr[20];
  assign reg_rd    = bus.sel & ~bus.we &  bus.addr[20];
  assign pix_rd    = bus.sel & ~bus.we & ~bus.addr[20];
  assign start_req = reg_wr && (idx == 3'd5) && bus.din[0];
  assign clr_req   = reg_wr && (idx == 3'd5) && bus.din[1];
  assign empty     = (w_q == '0) || (h_q == '0);
  assign step      = (state == FILL) && !cpu_store;
  assign last_px   = (cx == x_end) && (cy == y_end);
  // 11-bit counters: anything beyond the 10/9-bit address fields is off-screen
  assign on_screen = ({1'b0, cx} < FB_W_L) && ({1'b0, cy} < FB_H_L)
                     && !cx[10] && (cy[10:9] == 2'b00);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start_req && !empty) state_nxt = FILL;
      FILL: if (step && last_px)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: CPU stores always own the port
  always_comb begin
    fb_sel  = 1'b0;
    fb_we   = 1'b0;
    fb_addr = '0;
    fb_din  = '0;
    busy    = (state == FILL);
    if (cpu_store) begin
      fb_sel  = 1'b1;
      fb_we   = 1'b1;
      fb_addr = bus.addr;
      fb_din  = bus.din;
    end else if (state == FILL && on_screen) begin
      fb_sel  = 1'b1;
      fb_we   = 1'b1;
      fb_addr = {13'b0, cx[9:0], cy[8:0]};
      fb_din  = {26'b0, wcolor};
    end
  end

  // Config registers, working copies, counters, done flag and read data
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      color_q  <= '0;
      done_q   <= 1'b0;
      wx0      <= '0;
      x_end    <= '0;
      y_end    <= '0;
      cx       <= '0;
      cy       <= '0;
      wcolor   <= '0;
      bus.dout <= '0;
    end else begin
      if (reg_wr) begin
        unique case (idx)
          3'd0:    x0_q    <= bus.din[9:0];
          3'd1:    y0_q    <= bus.din[8:0];
          3'd2:    w_q     <= bus.din[9:0];
          3'd3:    h_q     <= bus.din[8:0];
          3'd4:    color_q <= bus.din[5:0];
          default: ;
        endcase
      end

      // A start while idle beats a simultaneous clear; completion beats a clear
      if (state == IDLE && start_req) done_q <= empty;
      else if (step && last_px)       done_q <= 1'b1;
      else if (clr_req)               done_q <= 1'b0;

      if (state == IDLE && start_req && !empty) begin
        wx0    <= {1'b0, x0_q};
        x_end  <= {1'b0, x0_q} + {1'b0, w_q} - 11'd1;
        y_end  <= {2'b0, y0_q} + {2'b0, h_q} - 11'd1;
        cx     <= {1'b0, x0_q};
        cy     <= {2'b0, y0_q};
        wcolor <= color_q;
      end else if (step) begin
        if (cx == x_end) begin
          cx <= wx0;
          cy <= cy + 11'd1;
        end else begin
          cx <= cx + 11'd1;
        end
      end

      if (reg_rd) begin
        unique case (idx)
          3'd0:    bus.dout <= {22'b0, x0_q};
          3'd1:    bus.dout <= {23'b0, y0_q};
          3'd2:    bus.dout <= {22'b0, w_q};
          3'd3:    bus.dout <= {23'b0, h_q};
          3'd4:    bus.dout <= {26'b0, color_q};
          3'd5:    bus.dout <= {30'b0, done_q, busy};
          default: bus.dout <= '0;
        endcase
      end else if (pix_rd) begin
        bus.dout <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fb_fill_ctrl.sv
// Directed bench for fb_fill_ctrl: register access, fills, CPU stalls, clipping and reset abort.
module tb_fb_fill_ctrl;

  logic        clock;
  logic        reset;
  logic        fb_sel, fb_we, busy;
  logic [31:0] fb_addr, fb_din;

  int vectors    = 0;
  int miscompares = 0;

  fb_fill_ctrl_if bus ();

  fb_fill_ctrl #(.FB_W(640), .FB_H(480)) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .fb_sel  (fb_sel),
    .fb_we   (fb_we),
    .fb_addr (fb_addr),
    .fb_din  (fb_din),
    .busy    (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pixel addresses are (x << 9) | y
  logic [31:0] exp_a [0:5] = '{32'h403, 32'h603, 32'h803, 32'h404, 32'h604, 32'h804};
  logic [31:0] exp_c [0:1] = '{32'h4FDDF, 32'h4FFDF};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_bus();
    bus.sel  = 1'b0;
    bus.we   = 1'b0;
    bus.addr = '0;
    bus.din  = '0;
  endtask

  task automatic wr_reg(input logic [2:0] idx, input logic [31:0] data);
    bus.sel  = 1'b1;
    bus.we   = 1'b1;
    bus.addr = 32'h0010_0000 | {27'b0, idx, 2'b00};
    bus.din  = data;
    tick();
    idle_bus();
  endtask

  task automatic rd_reg(input logic [2:0] idx, input logic [31:0] exp, input string tag);
    bus.sel  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = 32'h0010_0000 | {27'b0, idx, 2'b00};
    tick();
    idle_bus();
    chk(tag, bus.dout, exp);
  endtask

  initial begin
    int k;
    logic cpu;
    reset = 1'b0;
    idle_bus();
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_fb_we", {31'b0, fb_we}, 32'd0);
    chk("rst_fb_sel", {31'b0, fb_sel}, 32'd0);
    chk("rst_dout", bus.dout, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    rd_reg(3'd5, 32'd0, "ctrl_after_rst");

    // Register width masking, unmapped index, pixel read, dout hold
    wr_reg(3'd0, 32'hFFFF_FFFF);
    rd_reg(3'd0, 32'h3FF, "x0_mask");
    tick();
    chk("dout_hold", bus.dout, 32'h3FF);
    rd_reg(3'd6, 32'd0, "rd_idx6");
    rd_reg(3'd0, 32'h3FF, "x0_again");
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = 32'h1234;
    tick();
    idle_bus();
    chk("rd_pixel", bus.dout, 32'd0);

    // Basic 3x2 fill
    wr_reg(3'd0, 32'd2);
    wr_reg(3'd1, 32'd3);
    wr_reg(3'd2, 32'd3);
    wr_reg(3'd3, 32'd2);
    wr_reg(3'd4, 32'h2A);
    rd_reg(3'd4, 32'h2A, "color_rd");
    wr_reg(3'd5, 32'd1);
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("f1_busy", {31'b0, busy}, 32'd1);
      chk("f1_we", {31'b0, fb_we}, 32'd1);
      chk("f1_addr", fb_addr, exp_a[c]);
      chk("f1_din", fb_din, 32'h2A);
      tick();
    end
    #1;
    chk("f1_busy_end", {31'b0, busy}, 32'd0);
    chk("f1_we_end", {31'b0, fb_we}, 32'd0);
    rd_reg(3'd5, 32'd2, "f1_ctrl");

    // Same fill with CPU stores in FILL cycles 2 and 4
    wr_reg(3'd5, 32'd1);
    k = 0;
    for (int c = 1; c <= 8; c++) begin
      cpu = (c == 2) || (c == 4);
      if (cpu) begin
        bus.sel = 1'b1; bus.we = 1'b1; bus.addr = 32'h1234; bus.din = 32'h15;
      end else begin
        idle_bus();
      end
      #1;
      chk("f2_busy", {31'b0, busy}, 32'd1);
      chk("f2_we", {31'b0, fb_we}, 32'd1);
      chk("f2_addr", fb_addr, cpu ? 32'h1234 : exp_a[k]);
      chk("f2_din", fb_din, cpu ? 32'h15 : 32'h2A);
      if (!cpu) k++;
      tick();
    end
    idle_bus();
    #1;
    chk("f2_busy_end", {31'b0, busy}, 32'd0);
    rd_reg(3'd5, 32'd2, "f2_ctrl");

    // Clipping at the bottom-right corner
    wr_reg(3'd0, 32'd638);
    wr_reg(3'd1, 32'd479);
    wr_reg(3'd2, 32'd4);
    wr_reg(3'd3, 32'd2);
    wr_reg(3'd5, 32'd1);
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("f3_busy", {31'b0, busy}, 32'd1);
      chk("f3_we", {31'b0, fb_we}, (c < 2) ? 32'd1 : 32'd0);
      if (c < 2) chk("f3_addr", fb_addr, exp_c[c]);
      tick();
    end
    #1;
    chk("f3_busy_end", {31'b0, busy}, 32'd0);
    rd_reg(3'd5, 32'd2, "f3_ctrl");

    // Zero-width start and done clear
    wr_reg(3'd5, 32'd2);
    rd_reg(3'd5, 32'd0, "clr_before_w0");
    wr_reg(3'd2, 32'd0);
    wr_reg(3'd5, 32'd1);
    #1;
    chk("w0_busy", {31'b0, busy}, 32'd0);
    chk("w0_we", {31'b0, fb_we}, 32'd0);
    rd_reg(3'd5, 32'd2, "w0_ctrl");
    wr_reg(3'd5, 32'd2);
    rd_reg(3'd5, 32'd0, "w0_clr");

    // 10x10 fill: recolor and restart attempts ignored, reset aborts
    wr_reg(3'd0, 32'd0);
    wr_reg(3'd1, 32'd0);
    wr_reg(3'd2, 32'd10);
    wr_reg(3'd3, 32'd10);
    wr_reg(3'd4, 32'h01);
    wr_reg(3'd5, 32'd1);
    for (int c = 1; c <= 19; c++) begin
      if (c == 5) begin
        bus.sel = 1'b1; bus.we = 1'b1; bus.addr = 32'h0010_0010; bus.din = 32'h3F;
      end else if (c == 6) begin
        bus.sel = 1'b1; bus.we = 1'b1; bus.addr = 32'h0010_0014; bus.din = 32'h1;
      end else begin
        idle_bus();
      end
      #1;
      chk("f5_busy", {31'b0, busy}, 32'd1);
      chk("f5_we", {31'b0, fb_we}, 32'd1);
      chk("f5_addr", fb_addr, (((c - 1) % 10) << 9) | ((c - 1) / 10));
      chk("f5_din", fb_din, 32'h01);
      tick();
    end
    idle_bus();
    reset = 1'b0;
    #1;
    chk("abort_we", {31'b0, fb_we}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_dout", bus.dout, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_we", {31'b0, fb_we}, 32'd0);
    chk("post_rst_busy", {31'b0, busy}, 32'd0);
    rd_reg(3'd5, 32'd0, "post_rst_ctrl");
    rd_reg(3'd4, 32'd0, "post_rst_color");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fb_fill_ctrl.md
Name: fb_fill_ctrl

Overview:
- Framebuffer write controller that sits between the CPU data bus and the framebuffer write port.
- CPU pixel stores pass straight through to the framebuffer.
- A memory-mapped rectangle-fill engine sequences one pixel write per cycle into the same port.
- CPU stores have priority; the engine stalls while the CPU holds the port.

Parameters:
- FB_W, 640, visible width in pixels; pixels with x >= FB_W are never written.
- FB_H, 480, visible height in pixels; pixels with y >= FB_H are never written.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- sel  in  1  CPU bus select for this block.
- we  in  1  CPU write enable.
- addr  in  32  CPU address. addr[20]=0: pixel store. addr[20]=1: control register, index addr[4:2].
- din  in  32  CPU write data.
- dout  out  32  registered register read data.
- fb_sel  out  1  framebuffer port enable.
- fb_we  out  1  framebuffer write enable.
- fb_addr  out  32  framebuffer pixel address = {13'b0, x[9:0], y[8:0]}.
- fb_din  out  32  pixel data; only [5:0] significant (RRGGBB), [31:6]=0.
- busy  out  1  fill in progress.

Behaviour:
- Reset (reset=0, asynchronous):
  - all config registers 0, state IDLE, busy=0, done=0, dout=0.
  - fb_sel=fb_we=0.
- Register map (index = addr[4:2]):
  - 0 X0[9:0]
  - 1 Y0[8:0]
  - 2 W[9:0]
  - 3 H[8:0]
  - 4 COLOR[5:0]
  - 5 CTRL. Write: bit0=1 starts a fill; bit1=1 clears done. Read: {30'b0, done, busy}.
  - Indices 6 and 7: writes ignored, reads 0.
  - Unused upper bits read 0.
- Reads (sel=1, we=0, addr[20]=1): dout valid the cycle after the request. A read of an unmapped index or a pixel address returns 0. dout holds its value otherwise.
- CPU pixel store (sel=1, we=1, addr[20]=0): same cycle, fb_sel=fb_we=1, fb_addr=addr, fb_din=din. Combinational pass-through with no added latency, regardless of engine state.
- Engine states: IDLE, FILL.
  - IDLE -> FILL on a CTRL start write while idle:
    - Latch X0, Y0, W, H, COLOR into working copies.
    - Set cx=X0, cy=Y0, busy=1, done=0.
  - Start with W=0 or H=0: stay IDLE, set done=1 next cycle, issue no fb writes.
  - Start while busy: ignored.
  - Config writes while busy are accepted but do not affect the running fill.
- FILL, each cycle:
  - If a CPU pixel store is present, the engine stalls: no engine write, counters hold.
  - Otherwise, if cx < FB_W and cy < FB_H: drive fb_sel=fb_we=1, fb_addr={13'b0, cx, cy}, fb_din={26'b0, COLOR}.
  - Otherwise (off-screen): no write, but the pixel slot is still consumed.
  - After the slot: cx advances. At cx = X0+W-1 it wraps to X0 and cy increments.
  - After the slot at (X0+W-1, Y0+H-1): go to IDLE, busy=0, done=1 on the same edge.
- Counter width: cx and cy are computed 11 bits wide so X0+W or Y0+H beyond 1023 do not alias. Pixels past the 10-bit or 9-bit range count as off-screen.
- Latency: an unstalled fill of W*H pixels keeps busy high for exactly W*H cycles. The first engine write appears in the cycle after the start write.
- done is sticky until cleared via CTRL bit1 or a new start. A start with clear both set: start wins, done=0.
- Reset asserted mid-fill: the fill aborts immediately and no further writes occur.

Test Plan:
- Reset then read CTRL (index 5) -> dout=0 next cycle; fb_we=0; busy=0.
- X0=2, Y0=3, W=3, H=2, COLOR=0x2A, start -> exactly 6 writes in consecutive cycles to (2,3),(3,3),(4,3),(2,4),(3,4),(4,4), fb_din=0x2A. Busy high 6 cycles, then CTRL reads 0x2.
- Same fill with CPU pixel stores at cycles 2 and 4 of FILL (addr=0x1234, din=0x15) -> those cycles show the CPU write. The engine writes the same 6 pixels in order; busy lasts 8 cycles.
- X0=638, Y0=479, W=4, H=2, start -> only (638,479) and (639,479) written; busy lasts 8 cycles; done=1.
- W=0, start -> no fb writes, busy never 1, CTRL reads 0x2. Then write CTRL=0x2 -> CTRL reads 0.
- Start a 10x10 fill; at cycle 5 rewrite COLOR=0x3F and issue start again; at cycle 20 pull reset low -> writes keep the original color, the second start is ignored, and writes stop immediately with busy=0 and done=0 at reset.
